// File: rtl/serial_cmd_pkg.sv
// Shared definitions for the bit-serial command sequencer: phase encoding,
// opcode values and the per-phase last-bit index.
package serial_cmd_pkg;

  typedef enum logic [2:0] {
    S_OP     = 3'b000,
    S_DATA   = 3'b001,
    S_ADDR   = 3'b010,
    S_ADDR_C = 3'b011,
    S_WRITE  = 3'b100
  } state_t;

  localparam logic [1:0] OP_LDD   = 2'b00;
  localparam logic [1:0] OP_LDA   = 2'b01;
  localparam logic [1:0] OP_WR    = 2'b10;
  localparam logic [1:0] OP_LDA_C = 2'b11;

  // Index of the last bit accepted in a phase; zero for phases that take no bits.
  function automatic int unsigned phase_last(input logic [2:0] st,
                                             input int unsigned data_w,
                                             input int unsigned addr_w);
    case (st)
      S_OP:             return 32'd1;
      S_DATA:           return data_w - 32'd1;
      S_ADDR, S_ADDR_C: return addr_w - 32'd1;
      default:          return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/serial_cmd_sequencer_bit_counter.sv
// Phase bit counter with synchronous clear/enable and a terminal compare
// against a limit supplied at run time.
module bit_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             at_limit
);

  // Counter register; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt <= {CNT_W{1'b0}};
    end else if (en) begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

  assign at_limit = (cnt == limit);

endmodule

// File: rtl/serial_cmd_sequencer.sv
// Bit-serial command sequencer: collects a 2-bit opcode, then steps through
// the data/address/write phase, emitting one-cycle datapath enables.
module serial_cmd_sequencer
  import serial_cmd_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             cmp,
  input  logic             abort,
  output logic [2:0]       state,
  output logic [1:0]       opcode,
  output logic             op_en,
  output logic             data_en,
  output logic             addr_en,
  output logic             wr_strobe,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic [CNT_W-1:0] bit_cnt
);

  state_t           state_q;
  state_t           state_next;
  logic [1:0]       opcode_next;
  logic             cmp_lat;
  logic             cmp_next;
  logic             done_next;
  logic             overrun_next;
  logic             cnt_clr;
  logic             cnt_en;
  logic             at_limit;
  logic [CNT_W-1:0] limit;

  assign limit = CNT_W'(phase_last(state_q, DATA_W, ADDR_W));

  bit_counter #(.CNT_W(CNT_W)) u_bit_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .limit    (limit),
    .cnt      (bit_cnt),
    .at_limit (at_limit)
  );

  // Phase register and the registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_OP;
      opcode  <= 2'b00;
      cmp_lat <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_next;
      opcode  <= opcode_next;
      cmp_lat <= cmp_next;
      done    <= done_next;
      overrun <= overrun_next;
    end
  end

  // Next-phase decode and enables; abort suppresses every enable this cycle.
  always_comb begin
    state_next   = state_q;
    opcode_next  = opcode;
    cmp_next     = cmp_lat;
    done_next    = 1'b0;
    overrun_next = 1'b0;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    op_en        = 1'b0;
    data_en      = 1'b0;
    addr_en      = 1'b0;
    wr_strobe    = 1'b0;
    if (abort) begin
      state_next = S_OP;
      cnt_clr    = 1'b1;
      cmp_next   = 1'b0;
    end else begin
      case (state_q)
        S_OP: begin
          op_en = bit_valid;
          if (bit_valid) begin
            opcode_next = {opcode[0], bit_in};
            if (at_limit) begin
              cnt_clr = 1'b1;
              case (opcode_next)
                OP_LDD:   state_next = S_DATA;
                OP_LDA:   state_next = S_ADDR;
                OP_WR:    state_next = S_WRITE;
                OP_LDA_C: begin
                  state_next = S_ADDR_C;
                  cmp_next   = cmp;
                end
                default:  state_next = S_OP;
              endcase
            end else begin
              cnt_en = 1'b1;
            end
          end else begin
            cnt_en = 1'b0;
          end
        end
        S_DATA, S_ADDR, S_ADDR_C: begin
          data_en = bit_valid & (state_q == S_DATA);
          addr_en = bit_valid & ((state_q == S_ADDR) | ((state_q == S_ADDR_C) & cmp_lat));
          if (bit_valid) begin
            if (at_limit) begin
              state_next = S_OP;
              cnt_clr    = 1'b1;
              done_next  = 1'b1;
            end else begin
              cnt_en = 1'b1;
            end
          end else begin
            cnt_en = 1'b0;
          end
        end
        S_WRITE: begin
          // A bit arriving during the write cycle is discarded, not counted.
          wr_strobe    = 1'b1;
          state_next   = S_OP;
          done_next    = 1'b1;
          overrun_next = bit_valid;
          cnt_clr      = 1'b1;
        end
        default: begin
          state_next = S_OP;
          cnt_clr    = 1'b1;
        end
      endcase
    end
  end

  assign state = state_q;
  assign busy  = (state_q != S_OP) || (bit_cnt != {CNT_W{1'b0}});

endmodule

// File: doc/serial_cmd_sequencer.md
Name: serial_cmd_sequencer

Overview:
Single-clock synchronous sequencer for the bit-serial command datapath: 2-bit opcode shift register, 16-bit data shift register, address register and data-register write.
- Consumes one qualified serial bit per bit_valid pulse.
- Tracks the command phase and bit count.
- Emits one-cycle enables to the datapath registers instead of gated clocks.
- Replaces the gated-clock state controller, counter and counter-reset logic in front of those registers.

Parameters:
DATA_W, 16, data shift-register length in bits
ADDR_W, 4, address field length in bits
CNT_W, 5, bit-counter width; must satisfy 2^CNT_W > max(DATA_W, ADDR_W)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
bit_valid  in  1  one-cycle strobe: bit_in is valid this cycle
bit_in  in  1  serial data bit
cmp  in  1  condition flag, sampled on the second opcode bit
abort  in  1  synchronous command abort
state  out  3  current phase encoding
opcode  out  2  latched opcode
op_en  out  1  opcode shift enable
data_en  out  1  data shift enable
addr_en  out  1  address shift enable
wr_strobe  out  1  data-register write, one cycle
busy  out  1  high whenever state != S_OP or opcode bit count != 0
done  out  1  one-cycle pulse, cycle after a command completes
overrun  out  1  one-cycle pulse: bit_valid dropped
bit_cnt  out  CNT_W  bits accepted in current phase

Behaviour:
- States (3-bit):
  - S_OP = 000
  - S_DATA = 001
  - S_ADDR = 010
  - S_ADDR_C = 011
  - S_WRITE = 100
  - Remaining codes are illegal and go to S_OP on the next cycle.
- Reset values: state = S_OP, opcode = 00, bit_cnt = 0, cmp_lat = 0, done = 0, overrun = 0. All enables and wr_strobe are 0.
- Enables are combinational from registered state and are valid in the same cycle as bit_in, so the datapath captures on that edge:
  - op_en = bit_valid & (state == S_OP)
  - data_en = bit_valid & (state == S_DATA)
  - addr_en = bit_valid & ((state == S_ADDR) | ((state == S_ADDR_C) & cmp_lat))
- S_OP:
  - On bit_valid: opcode <= {opcode[0], bit_in}; bit_cnt increments.
  - On the 2nd bit (bit_cnt == 1): decode the new opcode value and set bit_cnt <= 0.
    - 00 -> S_DATA
    - 01 -> S_ADDR
    - 10 -> S_WRITE
    - 11 -> S_ADDR_C, with cmp_lat <= cmp in the same cycle
- S_DATA: accepts DATA_W bits. On the bit with bit_cnt == DATA_W-1: go to S_OP, bit_cnt <= 0, done = 1 next cycle.
- S_ADDR and S_ADDR_C: same as S_DATA but ADDR_W bits. In S_ADDR_C, bits are consumed even when cmp_lat = 0; addr_en stays low (skip).
- S_WRITE:
  - wr_strobe = 1 for exactly one cycle (Moore output).
  - Next state is S_OP; done pulses the following cycle.
  - bit_valid in this cycle is dropped and overrun pulses the next cycle.
- abort:
  - Has priority over bit_valid.
  - Next state is S_OP; bit_cnt and cmp_lat clear; opcode is held.
  - No enable, wr_strobe or done is produced in the abort cycle.
- rst has priority over abort.
- Back-to-back bit_valid every cycle is supported with no bubbles between phases.
- opcode holds its last value after a command completes.

Decomposition:
- Package serial_cmd_pkg:
  - State localparams S_OP..S_WRITE.
  - Opcode constants OP_LDD = 00, OP_LDA = 01, OP_WR = 10, OP_LDA_C = 11.
  - Phase-length function returning the last-bit index per state.
- One sub-module, bit_counter:
  - CNT_W-wide counter with sync clear and enable.
  - Terminal-compare output against a runtime limit.
- The sequencer FSM and enable decode stay in serial_cmd_sequencer.

Test Plan:
- Reset, then bits 0,0 followed by 16 data bits 1010_1100_0011_0101 (one bit_valid every 3 cycles) -> op_en x2, data_en x16, state 000->001->000, done single pulse, bit_cnt 0 afterwards.
- Bits 1,0 -> state 100 for exactly one cycle, wr_strobe one cycle, done next cycle, busy low after.
- Bits 1,1 with cmp=0 at the 2nd bit, then 4 bits -> state 011, addr_en never high, bit_cnt reaches 3, then S_OP. Repeat with cmp=1 -> addr_en x4.
- Bits 0,1, then bit_valid every cycle for 4 bits, then immediately 1,0 -> addr_en x4 then wr_strobe with no idle cycle between phases.
- abort after 7 data bits -> state 000, bit_cnt 0, no done. Next bits 0,1 start a fresh address command.
- bit_valid asserted in the S_WRITE cycle -> overrun pulse; the bit is not counted toward the next opcode (bit_cnt stays 0).
